// File: rtl/bcd_updown_counter_if.sv
// Request/status bundle for the N-digit BCD up/down counter.
// The master drives the requests and observes count and status. The slave is the counter.
interface bcd_updown_counter_if #(
  parameter int DIGITS = 4
);
  logic                  d_clr;
  logic                  d_load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  d_inc;
  logic                  d_dec;
  logic [4*DIGITS-1:0]   count;
  logic                  ovf;
  logic                  unf;
  logic                  load_err;
  logic                  is_zero;

  modport master (
    output d_clr, d_load, load_val, d_inc, d_dec,
    input  count, ovf, unf, load_err, is_zero
  );

  modport slave (
    input  d_clr, d_load, load_val, d_inc, d_dec,
    output count, ovf, unf, load_err, is_zero
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// DIGITS-wide packed-BCD up/down counter with validated parallel load,
// wrap-or-saturate range ends, and one-cycle overflow/underflow/load-error pulses.
module bcd_updown_counter #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_updown_counter_if.slave  bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0] count_q;
  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic         ovf_q;
  logic         unf_q;
  logic         load_err_q;
  logic         all_nine;
  logic         all_zero;
  logic         load_ok;
  logic [3:0]   digit;
  logic [3:0]   ld_digit;
  logic         inc_only;
  logic         dec_only;

  // The running all_nine/all_zero terms act as the carry/borrow into each digit.
  // After the loop they report whether the whole count is at a range end.
  always_comb begin
    // NOTE: Every variable gets a default before the loop so that no path leaves it unassigned, which would infer a latch.
    inc_val  = '0;
    dec_val  = '0;
    all_nine = 1'b1;
    all_zero = 1'b1;
    load_ok  = 1'b1;
    digit    = '0;
    ld_digit = '0;
    // NOTE: Blocking assignments are deliberate here. Each loop iteration reads the carry/borrow written by the iteration before it.
    for (int i = 0; i < DIGITS; i++) begin
      digit    = count_q[4*i +: 4];
      ld_digit = bus.load_val[4*i +: 4];
      if (all_nine) inc_val[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      else          inc_val[4*i +: 4] = digit;
      if (all_zero) dec_val[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
      else          dec_val[4*i +: 4] = digit;
      all_nine = all_nine & (digit == 4'd9);
      all_zero = all_zero & (digit == 4'd0);
      if (ld_digit > 4'd9) load_ok = 1'b0;
    end
  end

  assign inc_only = bus.d_inc & ~bus.d_dec;
  assign dec_only = bus.d_dec & ~bus.d_inc;

  // NOTE: Registered state uses non-blocking assignments. Every flop then samples the values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      load_err_q <= 1'b0;
      if (bus.d_clr) begin
        count_q <= '0;
      end else if (bus.d_load) begin
        if (load_ok) count_q    <= bus.load_val;
        else         load_err_q <= 1'b1;
      end else if (inc_only) begin
        ovf_q <= all_nine;
        // inc_val is already all-zero at the top end, so wrapping needs no special case.
        if (!all_nine || WRAP) count_q <= inc_val;
      end else if (dec_only) begin
        unf_q <= all_zero;
        if (!all_zero || WRAP) count_q <= dec_val;
      end
    end
  end

  assign bus.count    = count_q;
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;
  assign bus.load_err = load_err_q;
  assign bus.is_zero  = ~|count_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter in three configurations: 4-digit wrap, 4-digit saturate, and 2-digit wrap.
// Stimulus queues hand-computed responses. A monitor pops and compares one entry after each edge.
module tb_bcd_updown_counter;
  typedef struct packed {
    logic [15:0] count;
    logic        ovf;
    logic        unf;
    logic        load_err;
    logic        is_zero;
  } exp_t;

  logic clk;
  logic reset;
  logic clk_en;

  bcd_updown_counter_if #(.DIGITS(4)) if_a ();
  bcd_updown_counter_if #(.DIGITS(4)) if_b ();
  bcd_updown_counter_if #(.DIGITS(2)) if_c ();

  bcd_updown_counter #(.DIGITS(4), .WRAP(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  bcd_updown_counter #(.DIGITS(4), .WRAP(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

  exp_t  q_a[$], q_b[$], q_c[$];
  string n_a[$], n_b[$], n_c[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  function automatic exp_t act_a();
    return '{count: if_a.count, ovf: if_a.ovf, unf: if_a.unf,
             load_err: if_a.load_err, is_zero: if_a.is_zero};
  endfunction
  function automatic exp_t act_b();
    return '{count: if_b.count, ovf: if_b.ovf, unf: if_b.unf,
             load_err: if_b.load_err, is_zero: if_b.is_zero};
  endfunction
  function automatic exp_t act_c();
    return '{count: {8'h00, if_c.count}, ovf: if_c.ovf, unf: if_c.unf,
             load_err: if_c.load_err, is_zero: if_c.is_zero};
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got count=%h ovf=%b unf=%b load_err=%b is_zero=%b, expected count=%h ovf=%b unf=%b load_err=%b is_zero=%b",
                  name, act.count, act.ovf, act.unf, act.load_err, act.is_zero,
                  exp.count, exp.ovf, exp.unf, exp.load_err, exp.is_zero);
  endtask

  // Drive one cycle of requests into the selected counter and queue the response expected after the next edge.
  task automatic step(input int which, input string name,
                      input logic clr, input logic load, input logic [15:0] val,
                      input logic inc, input logic dec,
                      input logic [15:0] ec, input logic eo, input logic eu, input logic ee);
    exp_t e;
    @(negedge clk);
    e = '{count: ec, ovf: eo, unf: eu, load_err: ee, is_zero: (ec == 16'h0000)};
    case (which)
      0: begin
        if_a.d_clr = clr; if_a.d_load = load; if_a.load_val = val;
        if_a.d_inc = inc; if_a.d_dec = dec;
        q_a.push_back(e); n_a.push_back(name);
      end
      1: begin
        if_b.d_clr = clr; if_b.d_load = load; if_b.load_val = val;
        if_b.d_inc = inc; if_b.d_dec = dec;
        q_b.push_back(e); n_b.push_back(name);
      end
      default: begin
        if_c.d_clr = clr; if_c.d_load = load; if_c.load_val = val[7:0];
        if_c.d_inc = inc; if_c.d_dec = dec;
        q_c.push_back(e); n_c.push_back(name);
      end
    endcase
  endtask

  // Monitor: every counter presents a result each cycle, so one entry is popped per edge while work is pending.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #2;
      if (q_a.size() != 0) begin e = q_a.pop_front(); nm = n_a.pop_front(); check({"a_", nm}, act_a(), e); end
      if (q_b.size() != 0) begin e = q_b.pop_front(); nm = n_b.pop_front(); check({"b_", nm}, act_b(), e); end
      if (q_c.size() != 0) begin e = q_c.pop_front(); nm = n_c.pop_front(); check({"c_", nm}, act_c(), e); end
    end
  end

  initial begin
    exp_t rst_exp;
    exp_t pend;
    int   drain;
    logic [15:0] ec;
    rst_exp = '{count: 16'h0000, ovf: 1'b0, unf: 1'b0, load_err: 1'b0, is_zero: 1'b1};
    clk_en = 1'b0;
    reset  = 1'b1;
    if_a.d_clr = 0; if_a.d_load = 0; if_a.load_val = '0; if_a.d_inc = 0; if_a.d_dec = 0;
    if_b.d_clr = 0; if_b.d_load = 0; if_b.load_val = '0; if_b.d_inc = 0; if_b.d_dec = 0;
    if_c.d_clr = 0; if_c.d_load = 0; if_c.load_val = '0; if_c.d_inc = 0; if_c.d_dec = 0;

    // The reset state must appear before any clock edge has occurred.
    #3;
    check("a_reset_noclk", act_a(), rst_exp);
    check("b_reset_noclk", act_b(), rst_exp);
    check("c_reset_noclk", act_c(), rst_exp);
    #2 reset = 1'b0;
    clk_en = 1'b1;

    // 4 digits, wrap: carry chain, overflow wrap, load validation, priority, borrow chain.
    step(0, "load_0999",   0,1,16'h0999,0,0, 16'h0999,0,0,0);
    step(0, "inc_carry",   0,0,16'h0000,1,0, 16'h1000,0,0,0);
    step(0, "load_9999",   0,1,16'h9999,0,0, 16'h9999,0,0,0);
    step(0, "inc_wrap",    0,0,16'h0000,1,0, 16'h0000,1,0,0);
    step(0, "ovf_drop",    0,0,16'h0000,0,0, 16'h0000,0,0,0);
    step(0, "load_0042",   0,1,16'h0042,0,0, 16'h0042,0,0,0);
    step(0, "load_bad",    0,1,16'h12A4,0,0, 16'h0042,0,0,1);
    step(0, "load_1234",   0,1,16'h1234,0,0, 16'h1234,0,0,0);
    step(0, "load_0500",   0,1,16'h0500,0,0, 16'h0500,0,0,0);
    step(0, "clr_prio",    1,1,16'h1234,1,0, 16'h0000,0,0,0);
    step(0, "load_0500b",  0,1,16'h0500,0,0, 16'h0500,0,0,0);
    step(0, "inc_dec_hold",0,0,16'h0000,1,1, 16'h0500,0,0,0);
    step(0, "load_over_dec",0,1,16'h0300,0,1,16'h0300,0,0,0);
    step(0, "dec_borrow",  0,0,16'h0000,0,1, 16'h0299,0,0,0);
    step(0, "clr_bad_load",1,1,16'h00F0,0,0, 16'h0000,0,0,0);
    step(0, "dec_wrap",    0,0,16'h0000,0,1, 16'h9999,0,1,0);
    step(0, "inc_after_wrap",0,0,16'h0000,1,0,16'h0000,1,0,0);
    step(0, "load_0077",   0,1,16'h0077,0,0, 16'h0077,0,0,0);
    step(0, "idle",        0,0,16'h0000,0,0, 16'h0077,0,0,0);

    // Asynchronous reset in the middle of operation, then normal operation on the first edge afterwards.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("a_reset_midop", act_a(), rst_exp);
    #1 reset = 1'b0;
    step(0, "inc_after_rst",0,0,16'h0000,1,0, 16'h0001,0,0,0);
    step(0, "idle2",       0,0,16'h0000,0,0, 16'h0001,0,0,0);

    // 4 digits, saturate.
    step(1, "dec_sat1",    0,0,16'h0000,0,1, 16'h0000,0,1,0);
    step(1, "dec_sat2",    0,0,16'h0000,0,1, 16'h0000,0,1,0);
    step(1, "dec_sat3",    0,0,16'h0000,0,1, 16'h0000,0,1,0);
    step(1, "unf_drop",    0,0,16'h0000,0,0, 16'h0000,0,0,0);
    step(1, "load_9999",   0,1,16'h9999,0,0, 16'h9999,0,0,0);
    step(1, "inc_sat",     0,0,16'h0000,1,0, 16'h9999,1,0,0);
    step(1, "dec_from_top",0,0,16'h0000,0,1, 16'h9998,0,0,0);
    step(1, "idle",        0,0,16'h0000,0,0, 16'h9998,0,0,0);

    // 2 digits, wrap: a full lap of 100 increments, then the borrow cases.
    for (int i = 1; i <= 100; i++) begin
      ec = {8'h00, 4'((i % 100) / 10), 4'(i % 10)};
      step(2, $sformatf("inc_lap_%0d", i), 0,0,16'h0000,1,0, ec, (i == 100),0,0);
    end
    step(2, "ovf_drop",    0,0,16'h0000,0,0, 16'h0000,0,0,0);
    step(2, "load_10",     0,1,16'h0010,0,0, 16'h0010,0,0,0);
    step(2, "dec_10",      0,0,16'h0000,0,1, 16'h0009,0,0,0);
    step(2, "clr",         1,0,16'h0000,0,0, 16'h0000,0,0,0);
    step(2, "dec_wrap",    0,0,16'h0000,0,1, 16'h0099,0,1,0);
    step(2, "idle",        0,0,16'h0000,0,0, 16'h0099,0,0,0);

    drain = 0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    #3;
    pend = '0;
    pend.count = 16'(q_a.size() + q_b.size() + q_c.size());
    check("scoreboard_drained", pend, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised N-digit BCD up/down counter for the display path. Successor to the two-digit mod-100 increment/clear counter.
- Adds DIGITS-wide range, decrement, parallel BCD load with digit validation, wrap-or-saturate mode, and overflow/underflow/load-error status pulses.
- Drives seven-segment multiplexing logic directly with packed BCD digits.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); count range 0 .. 10^DIGITS-1.
- WRAP, 1, 1 = wrap at range ends; 0 = saturate at range ends.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- d_clr  input  1  synchronous clear request.
- d_load  input  1  synchronous parallel-load request.
- load_val  input  4*DIGITS  packed BCD load value; digit i at [4i+3:4i].
- d_inc  input  1  increment request.
- d_dec  input  1  decrement request.
- count  output  4*DIGITS  registered packed BCD count; digit i at [4i+3:4i].
- ovf  output  1  one-cycle pulse: increment attempted at 10^DIGITS-1.
- unf  output  1  one-cycle pulse: decrement attempted at 0.
- load_err  output  1  one-cycle pulse: load rejected because a digit was >9.
- is_zero  output  1  high when every digit of count is 0; decoded from registers.

Behaviour:
- One clock: clk. Reset is asynchronous and active-high on port reset.
- Reset: count=0, ovf=0, unf=0, load_err=0, is_zero=1, effective immediately and independent of clk.
- Request priority, sampled each rising edge: d_clr > d_load > (d_inc xor d_dec).
- d_clr: count becomes 0 at that edge. A simultaneous load, inc or dec is ignored and no flag asserts.
- d_load:
  - Every load_val digit 0..9: count becomes load_val at that edge.
  - Any digit >9: count holds and load_err=1 for the following cycle.
- d_inc and d_dec both high with no clr/load: count holds, no flags.
- Increment, digit-serial carry chain:
  - Digit 0 always steps. Digit i steps only if digits 0..i-1 are all 9.
  - A stepping digit goes 9->0 with carry, else +1.
- Decrement, mirror borrow chain:
  - Digit i steps only if digits 0..i-1 are all 0.
  - A stepping digit goes 0->9 with borrow, else -1.
- Upper boundary, increment at all-9s:
  - WRAP=1: count becomes 0 and ovf=1.
  - WRAP=0: count holds at all-9s and ovf=1.
- Lower boundary, decrement at 0:
  - WRAP=1: count becomes all-9s and unf=1.
  - WRAP=0: count holds at 0 and unf=1.
- Status flags: ovf, unf and load_err are registered, high for exactly one cycle after the triggering edge, low otherwise.
  - Repeated attempts at a boundary on consecutive cycles produce a flag on every one of those cycles.
- Latency: count reflects a request one edge after it is sampled. No pipelining, so back-to-back requests every cycle are accepted.
- Count digits never hold values >9 in any state reachable from reset.
- Reset asserted mid-operation overrides all requests. The first edge after deassertion processes requests normally.

Test Plan:
- Reset asserted with no clock -> count=0000, is_zero=1, all flags 0.
- DIGITS=4, WRAP=1: load 0999, then d_inc -> count=1000, no flag. Load 9999, then d_inc -> count=0000, ovf=1 for exactly one cycle.
- DIGITS=4, WRAP=0: count=0000, d_dec held 3 cycles -> count stays 0000, unf=1 on all 3 cycles. Load 9999, then d_inc -> count stays 9999, ovf=1.
- Load 12A4 (digit 1=0xA) while count=0042 -> count stays 0042, load_err=1 for one cycle. Then load 1234 -> count=1234, load_err=0.
- Priority check:
  - d_clr+d_load+d_inc together with count=0500 -> count=0000, no flags.
  - d_inc+d_dec together -> count holds.
  - d_load+d_dec with load_val=0300 -> count=0300.
- DIGITS=2, WRAP=1: 100 d_inc pulses from 00 -> count returns to 00, ovf=1 exactly once. Then d_dec from 10 -> 09, and from 00 -> 99 with unf=1.
